// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer serializer: the
// serializer state type, the default word width and the index-width helper.
package fc_pkg;

    typedef enum logic {
        eIDLE = 1'b0,
        eSEND = 1'b1
    } fc_ser_state_t;

    localparam int FC_WORD_SIZE = 16;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int fc_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_word_counter.sv
// Word index counter for the serializer. It counts 0..N-1, saturates at
// N-1 (no wrap) and flags the terminal count so the parent can mark the
// final word of a vector.
module fc_word_counter
    import fc_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = fc_idx_width(N)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    localparam logic [W-1:0] LP_LAST = W'(N - 1);

    logic [W-1:0] r_count;

    // Clear wins over enable; enable advances only below the terminal count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LP_LAST)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == LP_LAST);

endmodule

// File: rtl/fc_serializer.sv
// Parallel-to-serial converter for the output of a fully-connected layer.
// A whole LAYER_HEIGHT-word vector is captured on a valid/ready handshake and
// its words are written one per cycle (word 0 first) into the next layer's
// FIFO through a full/write-enable interface.
//
// Handshakes:
//   upstream   - a vector transfers on a rising edge where valid_i && ready_o.
//                ready_o is high in eIDLE and in the cycle the final word of
//                the current vector is written, so back-to-back vectors have
//                no bubble. ready_o depends combinationally on full_i.
//   downstream - a word transfers on a rising edge where wen_o is high.
//                wen_o = (state == eSEND) && !full_i; while full_i is high
//                nothing advances and data_o holds.
//
// Build option: define FC_SERIALIZER_RELU_EN to clamp negative words to zero
// as they are serialized. Without it the words pass through unchanged.
//
// state_o exposes the FSM state for observation.
module fc_serializer
    import fc_pkg::*;
#(
    parameter int WORD_SIZE    = FC_WORD_SIZE,
    parameter int LAYER_HEIGHT = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
    input  logic                                  full_i,
    output logic                                  wen_o,
    output logic [WORD_SIZE-1:0]                  data_o,
    output logic                                  last_o,
    output fc_ser_state_t                         state_o
);

    localparam int IDX_W = fc_idx_width(LAYER_HEIGHT);

    fc_ser_state_t                          r_state;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] r_vec;

    logic             w_wen;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_tc;
    logic [IDX_W-1:0] w_index;
    logic [WORD_SIZE-1:0] w_word;

    assign w_wen    = (r_state == eSEND) && !full_i;
    assign w_last   = w_wen && w_tc;
    assign w_ready  = (r_state == eIDLE) || w_last;
    assign w_accept = valid_i && w_ready;

    // The index restarts on a new vector and also after the final word, so
    // an idle serializer always points at word 0.
    fc_word_counter #(
        .N (LAYER_HEIGHT)
    ) u_counter (
        .i_clk   (clk_i),
        .i_rst_n (reset_n_i),
        .i_clear (w_accept || w_last),
        .i_en    (w_wen),
        .o_count (w_index),
        .o_tc    (w_tc)
    );

    // FSM: capture a vector on accept, return to idle after its final word
    // unless the next vector is accepted in that same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= eIDLE;
            r_vec   <= '0;
        end else if (w_accept) begin
            r_state <= eSEND;
            r_vec   <= data_i;
        end else if (w_last) begin
            r_state <= eIDLE;
        end
    end

    // Word select: mux the held vector by the current index.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < LAYER_HEIGHT; i++) begin
            if (w_index == IDX_W'(i)) begin
                w_word = r_vec[i];
            end
        end
    end

`ifdef FC_SERIALIZER_RELU_EN
    assign data_o = w_word[WORD_SIZE-1] ? '0 : w_word;
`else
    assign data_o = w_word;
`endif

    assign ready_o = w_ready;
    assign wen_o   = w_wen;
    assign last_o  = w_last;
    assign state_o = r_state;

endmodule

// File: tb/tb_fc_serializer.sv
// Bench for fc_serializer: a LAYER_HEIGHT=4 instance and a LAYER_HEIGHT=1
// instance share clock and reset. A word-queue model tracks the words still
// owed downstream and is compared against both instances every cycle;
// directed scenarios add literal expectations.
module tb_fc_serializer;
    import fc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                valid4, full4, ready4, wen4, last4;
    logic [3:0][15:0]    data4;
    logic [15:0]         dout4;
    fc_ser_state_t       st4;

    logic                valid1, full1, ready1, wen1, last1;
    logic [0:0][15:0]    data1;
    logic [15:0]         dout1;
    fc_ser_state_t       st1;

    fc_serializer #(.WORD_SIZE(16), .LAYER_HEIGHT(4)) u_dut4 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .valid_i   (valid4),
        .ready_o   (ready4),
        .data_i    (data4),
        .full_i    (full4),
        .wen_o     (wen4),
        .data_o    (dout4),
        .last_o    (last4),
        .state_o   (st4)
    );

    fc_serializer #(.WORD_SIZE(16), .LAYER_HEIGHT(1)) u_dut1 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .valid_i   (valid1),
        .ready_o   (ready1),
        .data_i    (data1),
        .full_i    (full1),
        .wen_o     (wen1),
        .data_o    (dout1),
        .last_o    (last1),
        .state_o   (st1)
    );

    // ---------------- counters / checker ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] act_fn(input logic [15:0] w);
`ifdef FC_SERIALIZER_RELU_EN
        return w[15] ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    // ---------------- model: words still owed downstream ----------------
    logic [15:0] exp_q4[$];
    logic [15:0] exp_q1[$];

    // A write pops the front word; a vector is accepted when nothing is
    // owed, or when the last owed word leaves this cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q4.delete();
            exp_q1.delete();
        end else begin
            if (exp_q4.size() > 0 && !full4) begin
                void'(exp_q4.pop_front());
                if (valid4 && exp_q4.size() == 0)
                    for (int i = 0; i < 4; i++) exp_q4.push_back(data4[i]);
            end else if (exp_q4.size() == 0 && valid4) begin
                for (int i = 0; i < 4; i++) exp_q4.push_back(data4[i]);
            end
            if (exp_q1.size() > 0 && !full1) begin
                void'(exp_q1.pop_front());
                if (valid1 && exp_q1.size() == 0) exp_q1.push_back(data1[0]);
            end else if (exp_q1.size() == 0 && valid1) begin
                exp_q1.push_back(data1[0]);
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("m_rst_ready4", 32'(ready4), 32'(1));
            chk("m_rst_wen4",   32'(wen4),   32'(0));
            chk("m_rst_last4",  32'(last4),  32'(0));
            chk("m_rst_data4",  32'(dout4),  32'(0));
            chk("m_rst_wen1",   32'(wen1),   32'(0));
        end else begin
            chk("m_wen4",   32'(wen4),   32'(exp_q4.size() > 0 && !full4));
            chk("m_ready4", 32'(ready4), 32'(exp_q4.size() == 0 || (exp_q4.size() == 1 && !full4)));
            chk("m_last4",  32'(last4),  32'(exp_q4.size() == 1 && !full4));
            if (exp_q4.size() > 0 && !full4) chk("m_data4", 32'(dout4), 32'(act_fn(exp_q4[0])));
            chk("m_wen1",   32'(wen1),   32'(exp_q1.size() > 0 && !full1));
            chk("m_ready1", 32'(ready1), 32'(exp_q1.size() == 0 || !full1));
            chk("m_last1",  32'(last1),  32'(exp_q1.size() > 0 && !full1));
            if (exp_q1.size() > 0 && !full1) chk("m_data1", 32'(dout1), 32'(act_fn(exp_q1[0])));
        end
    end

    // ---------------- trace capture ----------------
    logic        tw[16];
    logic [15:0] td[16];
    logic        tl[16];
    logic        tr[16];

    int bp_wen [7] = '{1, 1, 0, 0, 0, 1, 1};
    int bp_data[7] = '{16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0004};

    // ---------------- driver tasks ----------------
    // Present v with valid4 until accepted; returns #1 after the accept edge.
    task automatic do_accept4(input logic [63:0] v);
        bit got;
        got    = 1'b0;
        valid4 = 1'b1;
        data4  = v;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready4) got = 1'b1;
        end
        chk("accept4", 32'(got), 32'(1));
        @(posedge clk); #1;
        valid4 = 1'b0;
        data4  = {$urandom(), $urandom()};
    endtask

    // Record n cycles of DUT4 outputs; fpat[k] is full_i during cycle k.
    task automatic trace4(input int n, input logic [15:0] fpat);
        for (int k = 0; k < n; k++) begin
            full4 = fpat[k];
            @(negedge clk);
            tw[k] = wen4; td[k] = dout4; tl[k] = last4; tr[k] = ready4;
            @(posedge clk); #1;
        end
        full4 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc_k;
        logic [15:0] relu_exp[4];

        rst_n  = 1'b0;
        valid4 = 1'b0; full4 = 1'b0; data4 = '0;
        valid1 = 1'b0; full1 = 1'b0; data1 = '0;

        // Reset state
        #3;
        chk("rst_ready4", 32'(ready4), 32'(1));
        chk("rst_wen4",   32'(wen4),   32'(0));
        chk("rst_last4",  32'(last4),  32'(0));
        chk("rst_data4",  32'(dout4),  32'(0));
        chk("rst_state4", 32'(st4),    32'(eIDLE));
        chk("rst_ready1", 32'(ready1), 32'(1));
        #9 rst_n = 1'b1;
        idle(1);

        // Basic: words 1,2,3,4 in four consecutive cycles
        do_accept4({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        trace4(5, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            chk("basic_wen",   32'(tw[k]), 32'(1));
            chk("basic_data",  32'(td[k]), 32'(k + 1));
            chk("basic_last",  32'(tl[k]), 32'(k == 3));
            chk("basic_ready", 32'(tr[k]), 32'(k == 3));
        end
        chk("basic_idle_wen", 32'(tw[4]), 32'(0));

        // Backpressure: full for 3 cycles after the 2nd write
        do_accept4({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        trace4(8, 16'b0000_0000_0001_1100);
        for (int k = 0; k < 7; k++) begin
            chk("bp_wen",  32'(tw[k]), 32'(bp_wen[k]));
            chk("bp_data", 32'(td[k]), 32'(bp_data[k]));
        end
        chk("bp_last",     32'(tl[6]), 32'(1));
        chk("bp_done_wen", 32'(tw[7]), 32'(0));

        // Back-to-back: valid held high, A then B, no bubble
        valid4 = 1'b1;
        data4  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        @(negedge clk);
        chk("b2b_ready_idle", 32'(ready4), 32'(1));
        @(posedge clk); #1;
        data4 = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
        acc_k = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tw[k] = wen4; td[k] = dout4;
            if (ready4 && valid4) acc_k = k;
            @(posedge clk); #1;
            if (acc_k >= 0) valid4 = 1'b0;
        end
        chk("b2b_acc_cycle", 32'(acc_k), 32'(3));
        for (int k = 0; k < 8; k++) begin
            chk("b2b_wen",  32'(tw[k]), 32'(1));
            chk("b2b_data", 32'(td[k]), 32'((k < 4) ? (16'h00A0 + k) : (16'h00B0 + k - 4)));
        end
        idle(2);

        // Reset mid-vector: abandon after two of four words
        do_accept4({16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0});
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        chk("mid_pre_wen",  32'(wen4),  32'(1));
        chk("mid_pre_data", 32'(dout4), 32'(16'h00D2));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_wen",   32'(wen4),   32'(0));
        chk("mid_async_ready", 32'(ready4), 32'(1));
        chk("mid_async_last",  32'(last4),  32'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_accept4({16'h00E3, 16'h00E2, 16'h00E1, 16'h00E0});
        trace4(5, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            chk("mid_new_wen",  32'(tw[k]), 32'(1));
            chk("mid_new_data", 32'(td[k]), 32'(16'h00E0 + k));
        end
        chk("mid_new_idle", 32'(tw[4]), 32'(0));

        // LAYER_HEIGHT=1: one write per cycle, every write is last
        valid1   = 1'b1;
        data1[0] = 16'h1234;
        @(negedge clk);
        chk("h1_ready_idle", 32'(ready1), 32'(1));
        @(posedge clk); #1;
        data1[0] = 16'h5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tw[k] = wen1; td[k] = dout1; tl[k] = last1;
            @(posedge clk); #1;
            valid1   = 1'b0;
            data1[0] = 16'(($urandom()));
        end
        chk("h1_wen0",  32'(tw[0]), 32'(1));
        chk("h1_data0", 32'(td[0]), 32'(16'h1234));
        chk("h1_last0", 32'(tl[0]), 32'(1));
        chk("h1_wen1",  32'(tw[1]), 32'(1));
        chk("h1_data1", 32'(td[1]), 32'(16'h5678));
        chk("h1_last1", 32'(tl[1]), 32'(1));
        chk("h1_wen2",  32'(tw[2]), 32'(0));

        // Sign handling: ReLU clamps negative words only when enabled
`ifdef FC_SERIALIZER_RELU_EN
        relu_exp = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0005};
`else
        relu_exp = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0005};
`endif
        do_accept4({16'h0005, 16'hFFFF, 16'h7FFF, 16'h8000});
        trace4(4, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            chk("act_wen",  32'(tw[k]), 32'(1));
            chk("act_data", 32'(td[k]), 32'(relu_exp[k]));
        end
        chk("act_last", 32'(tl[3]), 32'(1));

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
